// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/stop/clear/lap control FSM
// Optional lap-hold feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int LAP_HOLD_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_lap_hold,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STOP  = 3'd2,
        ST_LAP   = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    state_e state_q, state_d;

`ifdef STOPWATCH_LAP_EN
    localparam int CW = $clog2(LAP_HOLD_TICKS + 1);

    logic [CW-1:0] hold_q, hold_d;
    logic          hold_expire;

    assign hold_expire = i_tick && (hold_q == CW'(LAP_HOLD_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_lap_inputs;
    assign unused_lap_inputs = i_btn_lap ^ i_tick;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority in every state is run > clear > lap; losers are dropped.
    always_comb begin
        state_d = state_q;
`ifdef STOPWATCH_LAP_EN
        hold_d  = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_btn_run) begin
                    state_d = ST_RUN;
                end else if (i_btn_clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_btn_run) begin
                    state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
                end else if (i_btn_lap) begin
                    state_d = ST_LAP;
`endif
                end
            end
            ST_STOP: begin
                if (i_btn_run) begin
                    state_d = ST_RUN;
                end else if (i_btn_clear) begin
                    state_d = ST_CLEAR;
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (i_btn_run) begin
                    state_d = ST_STOP;
                end else if (i_btn_lap || hold_expire) begin
                    state_d = ST_RUN;
                end else if (i_tick) begin
                    hold_d = hold_q + CW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
`endif
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign o_run   = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign o_clear = (state_q == ST_CLEAR);
    assign o_state = state_q;
`ifdef STOPWATCH_LAP_EN
    assign o_lap_hold = (state_q == ST_LAP);
`else
    assign o_lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard testbench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int H = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic       i_btn_lap = 1'b0;
    logic       o_run;
    logic       o_clear;
    logic       o_lap_hold;
    logic [2:0] o_state;

    int n_cmp = 0;
    int n_err = 0;

    int m_state = 0;
    int m_cnt = 0;
    logic [5:0] exp_q[$];

    stopwatch_ctrl #(.LAP_HOLD_TICKS(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (i_tick),
        .i_btn_run  (i_btn_run),
        .i_btn_clear(i_btn_clear),
        .i_btn_lap  (i_btn_lap),
        .o_run      (o_run),
        .o_clear    (o_clear),
        .o_lap_hold (o_lap_hold),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got run=%0b clr=%0b hold=%0b st=%0d, want run=%0b clr=%0b hold=%0b st=%0d",
                     tag, got[5], got[4], got[3], got[2:0], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [5:0] outs_of(input int s);
        logic r, c, h;
        r = (s == 1) || (s == 3);
        c = (s == 4);
        h = (s == 3);
        return {r, c, h, 3'(s)};
    endfunction

    function automatic logic [5:0] dut_outs();
        return {o_run, o_clear, o_lap_hold, o_state};
    endfunction

    // Reference: applies one cycle of button/tick inputs to the model state.
    task automatic model_step(input logic r, input logic c, input logic l, input logic t);
        int ns;
        ns = m_state;
        if (m_state == 0) begin
            ns = r ? 1 : (c ? 4 : 0);
        end else if (m_state == 1) begin
            if (r) ns = 2;
            else if (l && LAP_EN) begin ns = 3; m_cnt = 0; end
        end else if (m_state == 2) begin
            ns = r ? 1 : (c ? 4 : 2);
        end else if (m_state == 3) begin
            if (r) ns = 2;
            else if (l) ns = 1;
            else if (t && m_cnt == H - 1) ns = 1;
            else if (t) m_cnt = m_cnt + 1;
        end else begin
            ns = 0;
        end
        m_state = ns;
    endtask

    task automatic cycle(input string tag, input logic r, input logic c, input logic l, input logic t);
        logic [5:0] e;
        i_btn_run = r;
        i_btn_clear = c;
        i_btn_lap = l;
        i_tick = t;
        model_step(r, c, l, t);
        exp_q.push_back(outs_of(m_state));
        @(posedge clk);
        #1;
        i_btn_run = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_lap = 1'b0;
        i_tick = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, dut_outs(), e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle("idle", 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        check_val("reset_async", dut_outs(), 6'd0);
        @(posedge clk);
        #1;
        check_val("reset_held", dut_outs(), 6'd0);
        rst = 1'b0;

        idle(20);

        // run / stop / clear basic sequence
        idle(4);
        cycle("run_start", 1, 0, 0, 0);
        check_val("run_state", dut_outs(), {1'b1, 1'b0, 1'b0, 3'd1});
        idle(4);
        cycle("run_stop", 1, 0, 0, 0);
        check_val("stop_state", dut_outs(), {1'b0, 1'b0, 1'b0, 3'd2});
        idle(4);
        cycle("clear_pulse", 0, 1, 0, 0);
        check_val("clear_state", dut_outs(), {1'b0, 1'b1, 1'b0, 3'd4});
        cycle("clear_done", 0, 0, 0, 0);
        check_val("after_clear", dut_outs(), 6'd0);

        // clear ignored in RUN; run beats clear in STOP
        cycle("run", 1, 0, 0, 0);
        cycle("clr_in_run", 0, 1, 0, 0);
        cycle("stop", 1, 0, 0, 0);
        cycle("run_clr_prio", 1, 1, 0, 0);
        check_val("prio_run", dut_outs(), {1'b1, 1'b0, 1'b0, 3'd1});

        // lap with auto-release after H ticks
        cycle("lap_in", 0, 0, 1, 0);
        cycle("tick1", 0, 0, 0, 1);
        cycle("gap", 0, 0, 0, 0);
        cycle("tick2", 0, 0, 0, 1);
        cycle("tick3", 0, 0, 0, 1);
        check_val("lap_expired", dut_outs(), {1'b1, 1'b0, 1'b0, 3'd1});

        // run coinciding with expiry wins -> STOP
        cycle("lap_in2", 0, 0, 1, 0);
        cycle("tick1b", 0, 0, 0, 1);
        cycle("tick2b", 0, 0, 0, 1);
        cycle("run_at_exp", 1, 0, 0, 1);
        if (LAP_EN) check_val("run_exp_stop", dut_outs(), {1'b0, 1'b0, 1'b0, 3'd2});

        // lap coinciding with expiry -> RUN; clear and lap ignored appropriately
        cycle("resume", 1, 0, 0, 0);
        cycle("lap_in3", 0, 0, 1, 0);
        cycle("clr_in_lap", 0, 1, 0, 1);
        cycle("tick2c", 0, 0, 0, 1);
        cycle("lap_at_exp", 0, 0, 1, 1);
        cycle("lap_reenter", 0, 0, 1, 0);
        cycle("early_rel", 0, 0, 1, 0);
        cycle("lap_in4", 0, 0, 1, 0);
        cycle("tick_a", 0, 0, 0, 1);

        // asynchronous reset mid-LAP
        rst = 1'b1;
        #1;
        check_val("rst_mid_op", dut_outs(), 6'd0);
        m_state = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_released", dut_outs(), 6'd0);

        // held-high run toggles each cycle
        for (int k = 0; k < 4; k++) cycle("run_held", 1, 0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            cycle("random",
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
